// File: rtl/deserializer_flex.sv
// deserializer_flex: packs DATA_W-bit beats into DESER_W-bit words.
// Bit order is selectable, and a flush emits a partially filled word
// together with its valid bit count. There is no backpressure.
module deserializer_flex #(
  parameter int DESER_W   = 16,
  parameter int DATA_W    = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      data_val_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      flush_i,
  output logic                      deser_data_val_o,
  output logic [DESER_W-1:0]        deser_data_o,
  output logic [$clog2(DESER_W):0]  deser_data_cnt_o
);

  localparam int N     = DESER_W / DATA_W;
  localparam int CNT_W = $clog2(DESER_W) + 1;

  // Reject widths that cannot tile the output word exactly.
  generate
    if ((DESER_W % DATA_W) != 0 || DATA_W < 1 || DATA_W > DESER_W) begin : g_bad_width
      $error("deserializer_flex: DESER_W must be a non-zero multiple of DATA_W");
    end
  endgenerate

  logic [CNT_W-1:0]   beat_cnt_r;
  logic [DESER_W-1:0] acc_r;

  logic [CNT_W-1:0]   shift_s;
  logic [DESER_W-1:0] beat_ext_s;
  logic [DESER_W-1:0] beat_pos_s;
  logic [DESER_W-1:0] acc_next_s;
  logic [CNT_W-1:0]   beat_cnt_next_s;
  logic [CNT_W-1:0]   valid_bits_s;
  logic               full_s;
  logic               emit_s;

  // Place the incoming beat, fold it into the accumulator, decide whether a word leaves.
  always_comb begin
    beat_ext_s = DESER_W'(data_i);
    shift_s    = CNT_W'(beat_cnt_r * CNT_W'(DATA_W));
    if (MSB_FIRST) begin
      // Beat 0 sits at the top; later beats walk downwards.
      beat_pos_s = (beat_ext_s << (DESER_W - DATA_W)) >> shift_s;
    end else begin
      beat_pos_s = beat_ext_s << shift_s;
    end

    if (data_val_i) begin
      acc_next_s      = acc_r | beat_pos_s;
      beat_cnt_next_s = beat_cnt_r + CNT_W'(1);
    end else begin
      acc_next_s      = acc_r;
      beat_cnt_next_s = beat_cnt_r;
    end

    // A flush that lands with the last beat collapses into the single full-word output.
    full_s       = (beat_cnt_next_s == CNT_W'(N));
    emit_s       = full_s || (flush_i && (beat_cnt_next_s != '0));
    valid_bits_s = CNT_W'(beat_cnt_next_s * CNT_W'(DATA_W));
  end

  // Accumulator, beat counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      beat_cnt_r       <= '0;
      acc_r            <= '0;
      deser_data_val_o <= 1'b0;
      deser_data_o     <= '0;
      deser_data_cnt_o <= '0;
    end else begin
      deser_data_val_o <= emit_s;
      if (emit_s) begin
        deser_data_o     <= acc_next_s;
        deser_data_cnt_o <= valid_bits_s;
        acc_r            <= '0;
        beat_cnt_r       <= '0;
      end else begin
        acc_r            <= acc_next_s;
        beat_cnt_r       <= beat_cnt_next_s;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_flex.sv
// Self-checking bench for deserializer_flex: three instances
// (16/1/LSB-first, 16/4/MSB-first, 16/4/LSB-first) against a beat-list model.
module tb_deserializer_flex;

  logic       clk = 1'b0;
  logic       srst_s  [3];
  logic       val_s   [3];
  logic       flush_s [3];
  logic [3:0] d_s     [3];
  logic        out_val  [3];
  logic [15:0] out_data [3];
  logic [4:0]  out_cnt  [3];

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Model state: list of pending beats per instance
  int          dw [3] = '{1, 4, 4};
  bit          msb[3] = '{1'b0, 1'b1, 1'b0};
  int          pend[3][16];
  int          pn [3];
  bit          ok [3];
  logic        exp_val [3];
  logic [15:0] exp_data[3];
  logic [4:0]  exp_cnt [3];

  // Observed strobes
  int          strobes  [3];
  int          last_cyc [3];
  int          prev_cyc [3];
  logic [15:0] last_data[3];
  logic [15:0] prev_data[3];
  logic [4:0]  last_cnt [3];

  always #5 clk = ~clk;

  deserializer_flex #(.DESER_W(16), .DATA_W(1), .MSB_FIRST(1'b0)) u0 (
    .clk_i(clk), .srst_i(srst_s[0]), .data_val_i(val_s[0]), .data_i(d_s[0][0]),
    .flush_i(flush_s[0]), .deser_data_val_o(out_val[0]), .deser_data_o(out_data[0]),
    .deser_data_cnt_o(out_cnt[0]));

  deserializer_flex #(.DESER_W(16), .DATA_W(4), .MSB_FIRST(1'b1)) u1 (
    .clk_i(clk), .srst_i(srst_s[1]), .data_val_i(val_s[1]), .data_i(d_s[1]),
    .flush_i(flush_s[1]), .deser_data_val_o(out_val[1]), .deser_data_o(out_data[1]),
    .deser_data_cnt_o(out_cnt[1]));

  deserializer_flex #(.DESER_W(16), .DATA_W(4), .MSB_FIRST(1'b0)) u2 (
    .clk_i(clk), .srst_i(srst_s[2]), .data_val_i(val_s[2]), .data_i(d_s[2]),
    .flush_i(flush_s[2]), .deser_data_val_o(out_val[2]), .deser_data_o(out_data[2]),
    .deser_data_cnt_o(out_cnt[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Assemble a word from the pending beat list by direct bit placement.
  function automatic logic [15:0] build(input int i);
    logic [15:0] w;
    int pos;
    w = 16'h0;
    for (int k = 0; k < pn[i]; k++) begin
      for (int b = 0; b < dw[i]; b++) begin
        pos = msb[i] ? (16 - dw[i] * (k + 1) + b) : (k * dw[i] + b);
        w[pos] = 1'((pend[i][k] >> b) & 1);
      end
    end
    return w;
  endfunction

  // Model: predict what the outputs hold after this edge.
  always @(posedge clk) begin
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      exp_val[i] = 1'b0;
      if (srst_s[i]) begin
        ok[i] = 1'b1;
        pn[i] = 0;
        exp_data[i] = 16'h0;
        exp_cnt[i] = 5'd0;
      end else begin
        if (val_s[i]) begin
          pend[i][pn[i]] = int'(d_s[i]) & ((1 << dw[i]) - 1);
          pn[i]++;
        end
        if (pn[i] == 16 / dw[i] || (flush_s[i] && pn[i] > 0)) begin
          exp_val[i]  = 1'b1;
          exp_data[i] = build(i);
          exp_cnt[i]  = 5'(pn[i] * dw[i]);
          pn[i] = 0;
        end
      end
    end
  end

  // Compare every instance every cycle once it has been reset; log strobes.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ok[i]) begin
        chk($sformatf("val[%0d]@%0d", i, cyc_n), 32'(out_val[i]), 32'(exp_val[i]));
        chk($sformatf("data[%0d]@%0d", i, cyc_n), 32'(out_data[i]), 32'(exp_data[i]));
        chk($sformatf("cnt[%0d]@%0d", i, cyc_n), 32'(out_cnt[i]), 32'(exp_cnt[i]));
      end
      if (out_val[i] === 1'b1) begin
        strobes[i]++;
        prev_cyc[i]  = last_cyc[i];
        last_cyc[i]  = cyc_n;
        prev_data[i] = last_data[i];
        last_data[i] = out_data[i];
        last_cnt[i]  = out_cnt[i];
      end
    end
  end

  // One clock of stimulus on instance i, then inputs return to idle.
  task automatic cyc(input int i, input logic s, input logic v, input logic f, input logic [3:0] d);
    srst_s[i] = s; val_s[i] = v; flush_s[i] = f; d_s[i] = d;
    @(posedge clk);
    @(negedge clk);
    srst_s[i] = 1'b0; val_s[i] = 1'b0; flush_s[i] = 1'b0; d_s[i] = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    int base;
    for (int i = 0; i < 3; i++) begin
      srst_s[i] = 1'b1; val_s[i] = 1'b1; flush_s[i] = 1'b1; d_s[i] = 4'hF;
      pn[i] = 0; ok[i] = 1'b0; strobes[i] = 0; last_cyc[i] = 0; prev_cyc[i] = 0;
      exp_val[i] = 1'b0; exp_data[i] = 16'h0; exp_cnt[i] = 5'd0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      srst_s[i] = 1'b0; val_s[i] = 1'b0; flush_s[i] = 1'b0; d_s[i] = 4'h0;
    end
    #1;
    chk("rst_val", 32'(out_val[0]), 32'h0);
    chk("rst_data", 32'(out_data[0]), 32'h0);
    chk("rst_cnt", 32'(out_cnt[0]), 32'h0);
    chk("rst_strobes", 32'(strobes[0] + strobes[1] + strobes[2]), 32'h0);

    // 1: 1,0...0,1 -> 8001
    base = strobes[0];
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    for (int k = 1; k < 15; k++) cyc(0, 1'b0, 1'b1, 1'b0, 4'h0);
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    #1;
    chk("t1_strobe", 32'(strobes[0] - base), 32'd1);
    chk("t1_data", 32'(last_data[0]), 32'h8001);
    chk("t1_cnt", 32'(last_cnt[0]), 32'd16);
    idle(2);

    // 2: back-to-back A5A5 then 3C3C
    base = strobes[0];
    w = 16'hA5A5;
    for (int k = 0; k < 16; k++) cyc(0, 1'b0, 1'b1, 1'b0, {3'b000, w[k]});
    w = 16'h3C3C;
    for (int k = 0; k < 16; k++) cyc(0, 1'b0, 1'b1, 1'b0, {3'b000, w[k]});
    #1;
    chk("t2_strobes", 32'(strobes[0] - base), 32'd2);
    chk("t2_first", 32'(prev_data[0]), 32'hA5A5);
    chk("t2_second", 32'(last_data[0]), 32'h3C3C);
    chk("t2_spacing", 32'(last_cyc[0] - prev_cyc[0]), 32'd16);
    idle(2);

    // 3: nibble beats with gaps, both bit orders
    for (int i = 1; i < 3; i++) begin
      cyc(i, 1'b0, 1'b1, 1'b0, 4'hD); idle(1);
      cyc(i, 1'b0, 1'b1, 1'b0, 4'hE); idle(2);
      cyc(i, 1'b0, 1'b1, 1'b0, 4'hA); idle(1);
      cyc(i, 1'b0, 1'b1, 1'b0, 4'hD);
    end
    idle(1);
    #1;
    chk("t3_msb_data", 32'(last_data[1]), 32'hDEAD);
    chk("t3_msb_cnt", 32'(last_cnt[1]), 32'd16);
    chk("t3_lsb_data", 32'(last_data[2]), 32'hDAED);
    chk("t3_lsb_cnt", 32'(last_cnt[2]), 32'd16);

    // 4: 5 beats then flush; then flush with nothing pending
    base = strobes[0];
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h0);
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    idle(3);
    cyc(0, 1'b0, 1'b0, 1'b1, 4'h0);
    #1;
    chk("t4_data", 32'(last_data[0]), 32'h001B);
    chk("t4_cnt", 32'(last_cnt[0]), 32'd5);
    cyc(0, 1'b0, 1'b0, 1'b1, 4'h0);
    idle(2);
    #1;
    chk("t4_strobes", 32'(strobes[0] - base), 32'd1);

    // 5: flush coinciding with last beat, then flush-with-beat partial
    base = strobes[2];
    cyc(2, 1'b0, 1'b1, 1'b0, 4'h1);
    cyc(2, 1'b0, 1'b1, 1'b0, 4'h2);
    cyc(2, 1'b0, 1'b1, 1'b0, 4'h3);
    cyc(2, 1'b0, 1'b1, 1'b1, 4'h4);
    idle(1);
    #1;
    chk("t5_full_strobes", 32'(strobes[2] - base), 32'd1);
    chk("t5_full_data", 32'(last_data[2]), 32'h4321);
    chk("t5_full_cnt", 32'(last_cnt[2]), 32'd16);
    cyc(2, 1'b0, 1'b1, 1'b0, 4'h5);
    cyc(2, 1'b0, 1'b1, 1'b0, 4'h6);
    cyc(2, 1'b0, 1'b1, 1'b1, 4'h7);
    idle(1);
    #1;
    chk("t5_part_data", 32'(last_data[2]), 32'h0765);
    chk("t5_part_cnt", 32'(last_cnt[2]), 32'd12);

    // 6: reset mid-word discards the partial
    base = strobes[0];
    for (int k = 0; k < 9; k++) cyc(0, 1'b0, 1'b1, 1'b0, 4'h1);
    cyc(0, 1'b1, 1'b1, 1'b1, 4'h1);
    w = 16'h1234;
    for (int k = 0; k < 16; k++) cyc(0, 1'b0, 1'b1, 1'b0, {3'b000, w[k]});
    idle(3);
    #1;
    chk("t6_strobes", 32'(strobes[0] - base), 32'd1);
    chk("t6_data", 32'(last_data[0]), 32'h1234);
    chk("t6_cnt", 32'(last_cnt[0]), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
